// File: rtl/gate_fold_unit.sv
// gate_fold_unit: registered bitwise gate (AND/OR/XOR/XNOR/NAND/NOR/ANDN/PASS)
// behind a valid/ready handshake, streaming one result per beat or folding a
// burst into one word emitted on its last beat.
// Ports: clk, reset (sync, active high); in_valid/in_ready, a, b, op, fold,
// last on the input side; out_valid/out_ready, dout, out_count on the output.
// Optional macro GATE_FOLD_PARITY_EN adds dout_par, the XOR-reduce of dout.
module gate_fold_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             fold,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
`ifdef GATE_FOLD_PARITY_EN
    output logic             dout_par,
`endif
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       op_l, op_n;
    logic [WIDTH-1:0] dout_n;
    logic [CNT_W-1:0] count_n;
    logic             valid_n;
    logic             accept;
    logic [WIDTH-1:0] r_beat, r_lbeat, r_fold;
    logic [CNT_W-1:0] cnt_sat;

    function automatic logic [WIDTH-1:0] gate_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] res;
        case (sel)
            3'd0:    res = x & y;
            3'd1:    res = x | y;
            3'd2:    res = x ^ y;
            3'd3:    res = ~(x ^ y);
            3'd4:    res = ~(x & y);
            3'd5:    res = ~(x | y);
            3'd6:    res = x & ~y;
            default: res = x;
        endcase
        return res;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        op_n    = op_l;
        dout_n  = dout;
        count_n = out_count;
        // a pending result drops once consumed unless reloaded below
        valid_n = out_valid && !out_ready;
        r_beat  = gate_op(op, a, b);
        r_lbeat = gate_op(op_l, a, b);
        // left fold: running word is the left operand
        r_fold  = gate_op(op_l, acc, r_lbeat);
        cnt_sat = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (fold && !last) begin
                        acc_n   = r_beat;
                        cnt_n   = CNT_ONE;
                        op_n    = op;
                        state_n = ACCUM;
                    end else begin
                        dout_n  = r_beat;
                        count_n = CNT_ONE;
                        valid_n = 1'b1;
                    end
                end
                default: begin
                    if (!last) begin
                        acc_n = r_fold;
                        cnt_n = cnt_sat;
                    end else begin
                        dout_n  = r_fold;
                        count_n = cnt_sat;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            op_l      <= '0;
            dout      <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            op_l      <= op_n;
            dout      <= dout_n;
            out_count <= count_n;
            out_valid <= valid_n;
        end
    end

`ifdef GATE_FOLD_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) dout_par <= 1'b0;
        else       dout_par <= ^dout_n;
    end
`endif

endmodule

// File: tb/tb_gate_fold_unit.sv
// Self-checking bench for gate_fold_unit: streaming, backpressure, fold,
// mid-burst reset and counter saturation (second instance with CNT_W=2).
module tb_gate_fold_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] a, b;
    logic [2:0] op;
    logic       fold, last;
    logic       out_ready;

    logic       in_ready, out_valid;
    logic [7:0] dout;
    logic [7:0] out_count;
    logic       s_in_ready, s_out_valid;
    logic [7:0] s_dout;
    logic [1:0] s_out_count;
`ifdef GATE_FOLD_PARITY_EN
    logic       dout_par, s_dout_par;
`endif

    typedef struct {
        logic [7:0] d;
        logic [7:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    gate_fold_unit #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .fold(fold), .last(last),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout),
`ifdef GATE_FOLD_PARITY_EN
        .dout_par(dout_par),
`endif
        .out_count(out_count)
    );

    gate_fold_unit #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .op(op), .fold(fold), .last(last),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .dout(s_dout),
`ifdef GATE_FOLD_PARITY_EN
        .dout_par(s_dout_par),
`endif
        .out_count(s_out_count)
    );

    function automatic logic [7:0] model(input logic [2:0] o,
                                         input logic [7:0] x,
                                         input logic [7:0] y);
        unique case (1'b1)
            (o == 3'd0): return x & y;
            (o == 3'd1): return x | y;
            (o == 3'd2): return x ^ y;
            (o == 3'd3): return x ~^ y;
            (o == 3'd4): return ~(x & y);
            (o == 3'd5): return ~(x | y);
            (o == 3'd6): return x & ~y;
            default:     return x;
        endcase
    endfunction

    // Present one beat at negedge, hold until accepted, return at the
    // following negedge with in_valid dropped.
    task automatic drive_beat(input logic [7:0] ia, input logic [7:0] ib,
                              input logic [2:0] iop, input logic ifold,
                              input logic ilast);
        int waited = 0;
        a = ia; b = ib; op = iop; fold = ifold; last = ilast;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0; fold = 1'b0; last = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, dout, out_count, in_ready} !== {1'b0, 8'h00, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: v=%b d=%h c=%0d rdy=%b required 0 00 0 1",
                     out_valid, dout, out_count, in_ready);
        end
    endtask

    task automatic test_streaming();
        exp_t e;
        exp_q.push_back('{8'h55, 8'd1});
        drive_beat(8'hA5, 8'h0F, 3'd3, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || dout !== e.d || out_count !== e.c) begin
            n_fail++;
            $display("FAIL stream_xnor1: v=%b d=%h c=%0d required 1 %h %0d",
                     out_valid, dout, out_count, e.d, e.c);
        end
        exp_q.push_back('{8'h00, 8'd1});
        drive_beat(8'hFF, 8'h00, 3'd3, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || dout !== e.d || out_count !== e.c) begin
            n_fail++;
            $display("FAIL stream_xnor2: v=%b d=%h c=%0d required 1 %h %0d",
                     out_valid, dout, out_count, e.d, e.c);
        end
    endtask

    task automatic test_all_ops();
        exp_t e;
        logic [7:0] ra, rb;
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            exp_q.push_back('{model(3'(i % 8), ra, rb), 8'd1});
            drive_beat(ra, rb, 3'(i % 8), 1'b0, 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || dout !== e.d || out_count !== e.c) begin
                n_fail++;
                $display("FAIL op%0d a=%h b=%h: d=%h c=%0d required %h %0d",
                         i % 8, ra, rb, dout, out_count, e.d, e.c);
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL consume_clears: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        exp_q.push_back('{8'h03, 8'd1});
        drive_beat(8'h01, 8'h02, 3'd1, 1'b0, 1'b0);
        exp_q.push_back('{8'h0C, 8'd1});
        a = 8'h04; b = 8'h08; op = 3'd1; fold = 1'b0; last = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || dout !== e.d || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: v=%b d=%h rdy=%b required 1 %h 0",
                     out_valid, dout, in_ready, e.d);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || dout !== e.d || out_count !== e.c) begin
            n_fail++;
            $display("FAIL bp_second: v=%b d=%h c=%0d required 1 %h %0d",
                     out_valid, dout, out_count, e.d, e.c);
        end
        @(negedge clk);
    endtask

    task automatic test_fold_xor();
        exp_t e;
        drive_beat(8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
        drive_beat(8'h04, 8'h08, 3'd2, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fold_xor_early: out_valid=%b required 0", out_valid);
        end
        exp_q.push_back('{8'h3F, 8'd3});
        drive_beat(8'h10, 8'h20, 3'd2, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || dout !== e.d || out_count !== e.c) begin
            n_fail++;
            $display("FAIL fold_xor: v=%b d=%h c=%0d required 1 %h %0d",
                     out_valid, dout, out_count, e.d, e.c);
        end
    endtask

    task automatic test_fold_op_change();
        exp_t e;
        drive_beat(8'hFF, 8'hFF, 3'd3, 1'b1, 1'b0);
        exp_q.push_back('{8'hF0, 8'd2});
        drive_beat(8'h00, 8'h0F, 3'd0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || dout !== e.d || out_count !== e.c) begin
            n_fail++;
            $display("FAIL fold_op_latched: v=%b d=%h c=%0d required 1 %h %0d",
                     out_valid, dout, out_count, e.d, e.c);
        end
        // NAND left-fold: ~(acc & ~(a&b))
        drive_beat(8'hF0, 8'h3C, 3'd4, 1'b1, 1'b0);
        exp_q.push_back('{model(3'd4, model(3'd4, 8'hF0, 8'h3C),
                                model(3'd4, 8'h5A, 8'hFF)), 8'd2});
        drive_beat(8'h5A, 8'hFF, 3'd1, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== e.d || out_count !== e.c) begin
            n_fail++;
            $display("FAIL fold_nand: d=%h c=%0d required %h %0d",
                     dout, out_count, e.d, e.c);
        end
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        drive_beat(8'h11, 8'h22, 3'd1, 1'b1, 1'b0);
        drive_beat(8'h44, 8'h88, 3'd1, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({out_valid, dout, out_count} !== {1'b0, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_reset: v=%b d=%h c=%0d required 0 00 0",
                     out_valid, dout, out_count);
        end
        exp_q.push_back('{8'h30, 8'd1});
        drive_beat(8'hF0, 8'h3C, 3'd0, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || dout !== e.d || out_count !== e.c) begin
            n_fail++;
            $display("FAIL after_reset_and: v=%b d=%h c=%0d required 1 %h %0d",
                     out_valid, dout, out_count, e.d, e.c);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [7:0] vals [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        for (int i = 0; i < 5; i++) begin
            if (i == 4) exp_q.push_back('{8'h1F, 8'd3});
            drive_beat(vals[i], 8'h00, 3'd1, 1'b1, (i == 4));
        end
        e = exp_q.pop_front();
        n_checks++;
        if (s_out_valid !== 1'b1 || s_dout !== e.d || {6'd0, s_out_count} !== e.c) begin
            n_fail++;
            $display("FAIL sat_cnt2: v=%b d=%h c=%0d required 1 %h %0d",
                     s_out_valid, s_dout, s_out_count, e.d, e.c);
        end
        n_checks++;
        if (dout !== 8'h1F || out_count !== 8'd5) begin
            n_fail++;
            $display("FAIL sat_cnt8: d=%h c=%0d required 1f 5", dout, out_count);
        end
`ifdef GATE_FOLD_PARITY_EN
        n_checks++;
        if (s_dout_par !== 1'b1 || dout_par !== 1'b1) begin
            n_fail++;
            $display("FAIL parity: par=%b/%b required 1", s_dout_par, dout_par);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_all_ops();
        test_backpressure();
        test_fold_xor();
        test_fold_op_change();
        test_reset_mid_burst();
        test_saturation();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
